// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: sequential advance, stalls,
// branch/jump/jr redirects with one delay slot, and exception entry with EPC capture.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             in_delay_slot,
  output logic [WIDTH-1:0] epc,
  output logic             addr_err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic {SEQ, DELAY} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [WIDTH-1:0] tgt_reg, tgt_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic             addr_err_reg, addr_err_next;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic             jr_misaligned;

  assign seq_pc        = fetch_pc_reg + STEP_W;
  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign branch_tgt    = seq_pc + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_tgt      = {seq_pc[WIDTH-1:28], jump_index, 2'b00};
  assign jr_misaligned = (jr_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= SEQ;
      fetch_pc_reg <= RESET_VECTOR;
      tgt_reg      <= '0;
      epc_reg      <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      tgt_reg      <= tgt_next;
      epc_reg      <= epc_next;
      addr_err_reg <= addr_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    tgt_next      = tgt_reg;
    epc_next      = epc_reg;
    addr_err_next = 1'b0;
    if (exception) begin
      // A faulting delay slot reports the branch that owns it.
      fetch_pc_next = EXC_VECTOR;
      state_next    = SEQ;
      tgt_next      = '0;
      epc_next      = (state_reg == DELAY) ? (fetch_pc_reg - STEP_W) : fetch_pc_reg;
    end else if (!stall) begin
      case (state_reg)
        DELAY: begin
          fetch_pc_next = tgt_reg;
          state_next    = SEQ;
        end
        default: begin
          fetch_pc_next = seq_pc;
          if (jr) begin
            if (jr_misaligned) begin
              addr_err_next = 1'b1;
            end else begin
              tgt_next   = jr_target;
              state_next = DELAY;
            end
          end else if (jump) begin
            tgt_next   = jump_tgt;
            state_next = DELAY;
          end else if (branch_taken) begin
            tgt_next   = branch_tgt;
            state_next = DELAY;
          end
        end
      endcase
    end
  end

  assign pc            = fetch_pc_reg;
  assign pc_next       = seq_pc;
  assign in_delay_slot = (state_reg == DELAY);
  assign epc           = epc_reg;
  assign addr_err      = addr_err_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios followed by random control traffic,
// all checked against a queue-based model of the fetch address stream.
module tb_pc_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        exception = 1'b0;
  logic [31:0] pc, pc_next, epc;
  logic        in_delay_slot, addr_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: the pending redirect is a queue holding at most one target.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_aerr;
  logic [31:0] pending[$];

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target), .exception(exception),
    .pc(pc), .pc_next(pc_next), .in_delay_slot(in_delay_slot),
    .epc(epc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_next"}, pc_next, m_pc + 32'd4);
    check({tag, ".ds"}, {31'd0, in_delay_slot}, {31'd0, pending.size() != 0});
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".aerr"}, {31'd0, addr_err}, {31'd0, m_aerr});
    $display("[TB] %s pc=%08h ds=%0d epc=%08h aerr=%0d", tag, pc, in_delay_slot, epc, addr_err);
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_epc = '0;
    m_aerr = 1'b0;
    pending.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    logic [31:0] seq;
    logic [31:0] off;
    m_aerr = 1'b0;
    if (exception) begin
      m_epc = (pending.size() != 0) ? m_pc - 32'd4 : m_pc;
      m_pc = EXC;
      pending.delete();
    end else if (!stall) begin
      if (pending.size() != 0) begin
        m_pc = pending.pop_front();
      end else begin
        seq = m_pc + 32'd4;
        off = 32'($signed(branch_offset)) * 32'd4;
        if (jr) begin
          if (jr_target % 4 != 0) m_aerr = 1'b1;
          else pending.push_back(jr_target);
        end else if (jump) begin
          pending.push_back((seq & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4));
        end else if (branch_taken) begin
          pending.push_back(seq + off);
        end
        m_pc = seq;
      end
    end
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
  endtask

  // Apply the current inputs for one clock, then compare.
  task automatic step(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  // Reach an arbitrary aligned address through a jr redirect.
  task automatic goto_addr(input logic [31:0] a);
    jr = 1; jr_target = a;
    step("goto.req");
    step("goto.ds");
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("free");

    // Backward branch, then the same with a 2-cycle stall in the slot.
    goto_addr(32'h100);
    branch_taken = 1; branch_offset = 16'hFFFC;
    step("br.req");
    step("br.tgt");
    check("br.target", pc, 32'h0000_00F4);
    goto_addr(32'h100);
    branch_taken = 1; branch_offset = 16'hFFFC;
    step("brs.req");
    stall = 1; step("brs.stall0");
    stall = 1; step("brs.stall1");
    step("brs.tgt");

    // Jump, then jump and jr together.
    goto_addr(32'h0040_0010);
    jump = 1; jump_index = 26'h010_0000;
    step("j.req");
    step("j.tgt");
    check("j.target", pc, 32'h0040_0000);
    goto_addr(32'h0040_0010);
    jump = 1; jump_index = 26'h010_0000; jr = 1; jr_target = 32'h2000;
    step("jjr.req");
    step("jjr.tgt");

    // Misaligned jr.
    goto_addr(32'h20);
    jr = 1; jr_target = 32'h2002;
    step("ma.req");
    step("ma.next");

    // Exception in a delay slot, and exception during a stall.
    goto_addr(32'h100);
    branch_taken = 1; branch_offset = 16'h0040;
    step("exds.req");
    exception = 1; step("exds.exc");
    step("exds.after");
    goto_addr(32'h50);
    stall = 1; exception = 1; step("exst.exc");

    // Asynchronous reset while a redirect is pending.
    goto_addr(32'h300);
    jump = 1; jump_index = 26'h3FF_FFFF;
    step("rst.req");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst.async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("rst.rel");

    // Wrap-around.
    goto_addr(32'hFFFF_FFFC);
    step("wrap");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 4) == 0);
      exception     = ($urandom_range(0, 19) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = 16'($urandom);
      jump          = ($urandom_range(0, 5) == 0);
      jump_index    = 26'($urandom);
      jr            = ($urandom_range(0, 5) == 0);
      jr_target     = $urandom;
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
